// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    START = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Big-endian packing: the first byte of a word ends up in bits 31:24.
  localparam bit BIG_ENDIAN = 1'b1;

  // Fold one stream byte into a partially packed word.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [7:0]  b);
    return BIG_ENDIAN ? {word[23:0], b} : {b, word[31:8]};
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Shift register that assembles four stream bytes into one 32-bit word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  // Shift accepted bytes in; clear restarts packing at byte 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= pack_byte(word, byte_in);
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // High in the cycle whose shift completes the word.
  assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a byte stream into instruction memory
// and holds the core in reset until the whole program is written.
//
// Stream handshake: a byte transfers on a rising edge where s_valid and
// s_ready are both 1. s_ready depends only on state and reload, never on
// s_valid; the source must hold s_data/s_last stable until the transfer.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reload,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          done,
  output logic          err,
  output loader_state_t state_dbg
);

  loader_state_t state, state_next;
  logic [AW-1:0] word_cnt;
  logic          last_q;
  logic          accept;
  logic [31:0]   word;
  logic          word_full;

  assign accept    = s_valid && s_ready;
  assign state_dbg = state;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (reload),
    .shift_en  (accept),
    .byte_in   (s_data),
    .word      (word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= state_next;
  end

  // Next-state logic; reload wins from every state.
  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = LOAD;
    end else begin
      case (state)
        START: state_next = LOAD;
        LOAD: begin
          if (accept) begin
            if (word_full)   state_next = WRITE;
            else if (s_last) state_next = ERR;   // program ends mid-word
          end
        end
        WRITE: begin
          if (last_q)                            state_next = RUN;
          else if (word_cnt == AW'(DEPTH - 1))   state_next = ERR;  // memory full
          else                                   state_next = LOAD;
        end
        RUN:     state_next = RUN;
        ERR:     state_next = ERR;
        default: state_next = START;
      endcase
    end
  end

  // Word address counter and the last flag captured with the 4th byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      last_q   <= 1'b0;
    end else if (reload) begin
      word_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      if (state == LOAD && word_full) last_q <= s_last;
      if (state == WRITE)            word_cnt <= word_cnt + AW'(1);
    end
  end

  // Registered core reset: drops on the same edge that enters RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) core_reset <= 1'b1;
    else        core_reset <= (state_next != RUN);
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    s_ready    = (state == LOAD) && !reload;
    imem_we    = (state == WRITE);
    imem_addr  = (state == WRITE) ? word_cnt : '0;
    imem_wdata = (state == WRITE) ? word : '0;
    done       = (state == RUN);
    err        = (state == ERR);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 40;   // {8-bit address, 32-bit data}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reload = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          done;
  logic          err;
  loader_state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", {8'(imem_addr), imem_wdata}, '0);
      else check("imem_write", {8'(imem_addr), imem_wdata}, exp_q.pop_front());
    end
  end

  // Offer one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_reset"}, W'(core_reset), 1);
    check({tag, "_done"},       W'(done), 0);
    check({tag, "_err"},        W'(err), 0);
    check({tag, "_s_ready"},    W'(s_ready), 0);
    check({tag, "_imem_we"},    W'(imem_we), 0);
    check({tag, "_imem_addr"},  W'(imem_addr), 0);
    check({tag, "_imem_wdata"}, W'(imem_wdata), 0);
    check({tag, "_state"},      W'(state_dbg), W'(START));
  endtask

  logic [7:0] prog8 [8];

  initial begin
    prog8 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};

    // Reset block.
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 check("post_reset_state", W'(state_dbg), W'(START));
    @(negedge clk);
    check("start_to_load", W'(state_dbg), W'(LOAD));
    check("load_ready", W'(s_ready), 1);
    @(posedge clk);
    #1;

    // Two-word program at full rate; check release timing.
    exp_q.push_back({8'd0, 32'h20080005});
    exp_q.push_back({8'd1, 32'hAC080004});
    for (int i = 0; i < 8; i++) send_byte(prog8[i], i == 7);
    @(negedge clk);
    check("final_we", W'(imem_we), 1);
    check("final_we_core_reset", W'(core_reset), 1);
    check("final_we_done", W'(done), 0);
    @(negedge clk);
    check("run_core_reset", W'(core_reset), 0);
    check("run_done", W'(done), 1);
    check("run_we", W'(imem_we), 0);
    check("run_ready", W'(s_ready), 0);
    check("t1_writes", W'(exp_q.size()), 0);

    // Reload from RUN with a byte on offer; it must not be taken.
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    reload  = 1'b1;
    @(negedge clk);
    check("reload_run_ready", W'(s_ready), 0);
    @(posedge clk);
    #1;
    reload  = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("reload_core_reset", W'(core_reset), 1);
    check("reload_done", W'(done), 0);
    check("reload_state", W'(state_dbg), W'(LOAD));
    // Second reload while in LOAD: the offered byte must also be refused.
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    reload  = 1'b1;
    @(negedge clk);
    check("reload_load_ready", W'(s_ready), 0);
    @(posedge clk);
    #1;
    reload  = 1'b0;
    s_valid = 1'b0;
    exp_q.push_back({8'd0, 32'h12345678});
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    idle_gap(2);
    check("reload_run_done", W'(done), 1);
    check("reload_run_core_reset", W'(core_reset), 0);
    check("t2_writes", W'(exp_q.size()), 0);

    // Same program with random valid gaps.
    pulse_reload();
    exp_q.push_back({8'd0, 32'h20080005});
    exp_q.push_back({8'd1, 32'hAC080004});
    for (int i = 0; i < 8; i++) begin
      idle_gap($urandom_range(0, 1));
      send_byte(prog8[i], i == 7);
    end
    idle_gap(2);
    check("gap_done", W'(done), 1);
    check("t3_writes", W'(exp_q.size()), 0);

    // s_last on the 6th byte: one write, then error.
    pulse_reload();
    exp_q.push_back({8'd0, 32'h20080005});
    for (int i = 0; i < 6; i++) send_byte(prog8[i], i == 5);
    @(negedge clk);
    check("short_err", W'(err), 1);
    check("short_core_reset", W'(core_reset), 1);
    check("short_ready", W'(s_ready), 0);
    check("short_done", W'(done), 0);
    idle_gap(3);
    check("t4_writes", W'(exp_q.size()), 0);

    // Overflow: 16 bytes without s_last into a 4-word memory.
    pulse_reload();
    exp_q.push_back({8'd0, 32'h00010203});
    exp_q.push_back({8'd1, 32'h04050607});
    exp_q.push_back({8'd2, 32'h08090A0B});
    exp_q.push_back({8'd3, 32'h0C0D0E0F});
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    check("ovf_last_we", W'(imem_we), 1);
    @(negedge clk);
    check("ovf_err", W'(err), 1);
    check("ovf_core_reset", W'(core_reset), 1);
    s_valid = 1'b1;
    s_data  = 8'h10;
    repeat (4) @(negedge clk);
    check("ovf_17th_refused", W'(s_ready), 0);
    check("ovf_state", W'(state_dbg), W'(ERR));
    @(posedge clk);
    #1 s_valid = 1'b0;
    check("t5_writes", W'(exp_q.size()), 0);

    // Reload concurrent with WRITE: write completes, address restarts at 0.
    pulse_reload();
    exp_q.push_back({8'd0, 32'hA1A2A3A4});
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    reload = 1'b1;
    @(negedge clk);
    check("reload_write_we", W'(imem_we), 1);
    @(posedge clk);
    #1 reload = 1'b0;
    check("reload_write_state", W'(state_dbg), W'(LOAD));
    exp_q.push_back({8'd0, 32'hB1B2B3B4});
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_byte(8'hB4, 1'b1);
    idle_gap(2);
    check("reload_write_done", W'(done), 1);
    check("t6_writes", W'(exp_q.size()), 0);

    // Asynchronous reset after two bytes of a word.
    pulse_reload();
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk) reset = 1'b1;
    #1 check("async_rel_state", W'(state_dbg), W'(START));
    @(negedge clk);
    check("async_load", W'(state_dbg), W'(LOAD));
    @(posedge clk);
    #1;
    exp_q.push_back({8'd0, 32'hD1D2D3D4});
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b1);
    idle_gap(2);
    check("async_done", W'(done), 1);
    check("t7_writes", W'(exp_q.size()), 0);

    // Final report.
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Boot-time program loader; sits directly upstream of the single-cycle MIPS core and its instruction memory.
- Receives a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Writes the words to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset until the last word is written, then releases it.
- Supports a re-load request at any time.

## Interface
Parameters:
- DEPTH, 64, instruction-memory size in words
- AW, 6, word-address width, $clog2(DEPTH)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately
- reload  in  1  synchronous request to restart loading; single-cycle pulse or level
- s_valid  in  1  byte-stream valid
- s_ready  out  1  byte-stream ready
- s_data  in  8  stream byte
- s_last  in  1  marks final byte of program, qualified by s_valid
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  word address for write
- imem_wdata  out  32  word to write
- core_reset  out  1  active-high reset to the core; registered
- done  out  1  program loaded, core running
- err  out  1  load aborted (partial word or overflow)

## Operation
- States: START, LOAD, WRITE, RUN, ERR.
- Reset values:
  - State: START.
  - Outputs: core_reset=1, done=0, err=0, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - Counters: byte_cnt=0, word_cnt=0.
- START → LOAD unconditionally on the next clock.
- LOAD:
  - s_ready=1.
  - On each s_valid&s_ready: shift byte into the word register (first byte → bits 31:24) and increment byte_cnt (2 bits).
  - Capture s_last on the 4th byte → WRITE.
  - s_last on byte 1–3 → ERR.
- WRITE, one cycle:
  - s_ready=0, imem_we=1, imem_addr=word_cnt, imem_wdata=packed word.
  - word_cnt increments.
  - Next state: RUN if the captured last flag is set. Otherwise, if word_cnt==DEPTH-1 → ERR (overflow: memory full with no s_last). Otherwise → LOAD.
- RUN: s_ready=0, done=1, core_reset=0. Remains in RUN until reload or reset.
- ERR: s_ready=0, err=1, core_reset=1. Remains in ERR until reload or reset.
- reload (any state) → LOAD next cycle:
  - byte_cnt, word_cnt and last flag cleared.
  - core_reset=1, done=0, err=0.
  - s_ready is forced 0 in the reload cycle; a byte presented then is not accepted.
- Words beyond the last written address are untouched, never zero-filled.
- Bytes offered while s_ready=0 are neither consumed nor dropped; the source holds them.

## Timing
- Handshake: a transfer occurs on a rising edge with s_valid=1 and s_ready=1. s_ready never depends combinationally on s_valid.
- Throughput: 5 cycles per word at full stream rate (4 accept + 1 write).
- core_reset falls on the edge after the final WRITE cycle, the same edge done rises. The first core fetch at pc=0 sees the completed memory.
- imem_we is high exactly one cycle per word; address and data are stable during it.
- Asynchronous reset mid-load returns to START at once; a partially written program is not invalidated.
- reload concurrent with WRITE: the write completes this cycle, then counters clear and the state goes to LOAD.

## Structure
- Shared package prog_loader_pkg:
  - state enum loader_state_t {START, LOAD, WRITE, RUN, ERR}
  - BYTES_PER_WORD=4
  - big-endian packing constant
- Sub-module byte_packer: shift register plus 2-bit byte counter; outputs word and word_full. Cleared by clear input.
- Top: FSM, word counter, output registers.

## Test plan
- Stream 8 bytes 20 08 00 05 AC 08 00 04, s_last on the 8th → imem writes addr0=20080005, addr1=AC080004. core_reset falls and done=1 exactly one cycle after the second imem_we.
- Random s_valid gaps (50% duty) on the same stream → identical writes; no byte lost or duplicated.
- s_last on the 6th byte → no second write; err=1, core_reset stays 1, s_ready=0.
- DEPTH=4, 16 bytes without s_last → 4 writes to addr 0–3, then err=1; a 17th byte is not accepted.
- In RUN, pulse reload with s_valid=1 → byte not accepted in the reload cycle. core_reset=1 and done=0 next cycle; reload of 4 bytes with s_last → addr0 rewritten, RUN again.
- Assert reset low after 2 bytes of a word → all outputs at reset values immediately. After release: START, then LOAD; byte_cnt restarts at 0.
